// File: rtl/fft_avalon_pkg.sv
// rtl/fft_avalon_pkg.sv - shared types and default constants for the FFT Avalon result path
// Contents:
//   res_state_t : result-master FSM states (IDLE, FETCH, LOAD, WRITE, DONE)
//   NUM_SAMPLES : default words per frame
//   BASE_ADDR   : default first Avalon byte address of the output frame
//   ADDR_STRIDE : default byte increment between consecutive words
package fft_avalon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } res_state_t;

    localparam int          NUM_SAMPLES = 256;
    localparam logic [31:0] BASE_ADDR   = 32'h0850_0000;
    localparam int          ADDR_STRIDE = 2;

endpackage

// File: rtl/flex_counter.sv
// rtl/flex_counter.sv - parameterised up-counter with synchronous clear and programmable rollover
// Ports:
//   clk, n_rst    : clock, asynchronous active-low reset
//   clear         : synchronous clear to zero (wins over count_enable)
//   count_enable  : advance the count by one
//   rollover_val  : last value before the count wraps back to zero
//   count_out     : current count
//   rollover_flag : high while count_out equals rollover_val
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out <= '0;
        end else if (clear) begin
            count_out <= '0;
        end else if (count_enable) begin
            if (count_out == rollover_val) begin
                count_out <= '0;
            end else begin
                count_out <= count_out + 1'b1;
            end
        end
    end

    assign rollover_flag = (count_out == rollover_val);

endmodule

// File: rtl/avalon_result_master.sv
// rtl/avalon_result_master.sv - Avalon-MM write master draining FFT results to system memory
// Optional feature macro: AVALON_RESULT_IRQ_EN (adds dump_irq / irq_clear sticky interrupt)
// Ports:
//   clk, n_rst          : clock, asynchronous active-low reset
//   fft_done            : one-cycle pulse, result buffer holds a complete frame
//   rAddress / rData    : synchronous result RAM read port (data one cycle after address)
//   master_address      : Avalon byte address
//   master_write        : Avalon write request
//   master_writedata    : Avalon write data
//   master_byteenable   : 2'b11 during writes, 2'b00 otherwise
//   master_waitrequest  : slave stall
//   dump_busy           : high whenever the FSM is not idle
//   dump_done           : one-cycle pulse after the last word is accepted
//   dump_irq, irq_clear : (AVALON_RESULT_IRQ_EN only) sticky completion flag and its clear
module avalon_result_master #(
    parameter int          NUM_SAMPLES = fft_avalon_pkg::NUM_SAMPLES,
    parameter int          ADDR_W      = 9,
    parameter int          DATA_W      = 16,
    parameter logic [31:0] BASE_ADDR   = fft_avalon_pkg::BASE_ADDR,
    parameter int          ADDR_STRIDE = fft_avalon_pkg::ADDR_STRIDE
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              fft_done,
    output logic [ADDR_W-1:0] rAddress,
    input  logic [DATA_W-1:0] rData,
    output logic [31:0]       master_address,
    output logic              master_write,
    output logic [DATA_W-1:0] master_writedata,
    output logic [1:0]        master_byteenable,
    input  logic              master_waitrequest,
`ifdef AVALON_RESULT_IRQ_EN
    output logic              dump_irq,
    input  logic              irq_clear,
`endif
    output logic              dump_busy,
    output logic              dump_done
);

    import fft_avalon_pkg::*;

    res_state_t        state, next_state;
    logic [ADDR_W-1:0] index;
    logic              last_word;
    logic [DATA_W-1:0] wdata;
    logic              accepted;
    logic [31:0]       index_ext;

    assign accepted = (state == ST_WRITE) && !master_waitrequest;

    // Index is cleared while idle so every frame starts at word 0, and again
    // in DONE so an abandoned or finished frame never leaks into the next one.
    flex_counter #(
        .NUM_CNT_BITS(ADDR_W)
    ) u_index (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        ((state == ST_IDLE) || (state == ST_DONE)),
        .count_enable (accepted),
        .rollover_val (ADDR_W'(NUM_SAMPLES - 1)),
        .count_out    (index),
        .rollover_flag(last_word)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wdata <= '0;
        end else if (state == ST_LOAD) begin
            wdata <= rData;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (fft_done) next_state = ST_FETCH;
            ST_FETCH: next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_WRITE;
            ST_WRITE: if (accepted) next_state = last_word ? ST_DONE : ST_FETCH;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    assign index_ext = {{(32-ADDR_W){1'b0}}, index};

    // All bus outputs decode from state, so an asynchronous reset forces them
    // low immediately; during a stall state/index/wdata are frozen, which
    // holds address, data and byteenable stable.
    assign rAddress          = (state == ST_FETCH) ? index : '0;
    assign master_write      = (state == ST_WRITE);
    assign master_address    = master_write ? (BASE_ADDR + index_ext * 32'(ADDR_STRIDE)) : 32'd0;
    assign master_writedata  = master_write ? wdata : '0;
    assign master_byteenable = master_write ? 2'b11 : 2'b00;
    assign dump_busy         = (state != ST_IDLE);
    assign dump_done         = (state == ST_DONE);

`ifdef AVALON_RESULT_IRQ_EN
    // Set has priority so a completion coinciding with a clear is never lost.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dump_irq <= 1'b0;
        end else if (state == ST_DONE) begin
            dump_irq <= 1'b1;
        end else if (irq_clear) begin
            dump_irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_avalon_result_master.sv
// tb/tb_avalon_result_master.sv - self-checking bench for avalon_result_master
module tb_avalon_result_master;

    localparam int          N     = 256;
    localparam logic [31:0] BASE  = 32'h0850_0000;
    localparam int          CYC_PER_WORD = 3;

    logic        clk;
    logic        n_rst;
    logic        fft_done;
    logic [8:0]  rAddress;
    logic [15:0] rData;
    logic [31:0] master_address;
    logic        master_write;
    logic [15:0] master_writedata;
    logic [1:0]  master_byteenable;
    logic        master_waitrequest;
    logic        dump_busy;
    logic        dump_done;
`ifdef AVALON_RESULT_IRQ_EN
    logic        dump_irq;
    logic        irq_clear;
`endif

    avalon_result_master dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .fft_done          (fft_done),
        .rAddress          (rAddress),
        .rData             (rData),
        .master_address    (master_address),
        .master_write      (master_write),
        .master_writedata  (master_writedata),
        .master_byteenable (master_byteenable),
        .master_waitrequest(master_waitrequest),
`ifdef AVALON_RESULT_IRQ_EN
        .dump_irq          (dump_irq),
        .irq_clear         (irq_clear),
`endif
        .dump_busy         (dump_busy),
        .dump_done         (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result RAM: synchronous read, contents are the reference frame.
    logic [15:0] mem [N];
    always @(posedge clk) rData <= mem[rAddress[7:0]];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Monitor / scoreboard state (written by the negedge monitor, reset by main between frames)
    int          stall_mode = 0;   // 0 none, 1 five stalls on word 3, 2 random
    int          wcount, done_cnt, stalls, stall3, hold3, cyc, start_cyc;
    logic        prev_busy, prev_stalled;
    logic [31:0] held_addr;
    logic [15:0] held_data;

    task automatic new_frame();
        wcount = 0; done_cnt = 0; stalls = 0; stall3 = 0; hold3 = 0;
        cyc = 0; start_cyc = -1; prev_busy = 1'b0; prev_stalled = 1'b0;
    endtask

    initial begin
        logic wr;
        master_waitrequest = 1'b0;
        new_frame();
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                master_waitrequest = 1'b0;
                prev_stalled = 1'b0;
                prev_busy = 1'b0;
                continue;
            end
            cyc++;
            if (dump_busy && !prev_busy) start_cyc = cyc;
            prev_busy = dump_busy;
            wr = 1'b0;
            if (master_write) begin
                if (stall_mode == 1 && wcount == 3 && stall3 < 5) begin
                    wr = 1'b1;
                    stall3++;
                end else if (stall_mode == 2) begin
                    wr = ($urandom_range(0, 3) == 0);
                end
            end
            master_waitrequest = wr;
            check("byteenable", 64'(master_byteenable), master_write ? 64'd3 : 64'd0);
            if (prev_stalled) begin
                check("held_write", 64'(master_write), 64'd1);
                check("held_addr", 64'(master_address), 64'(held_addr));
                check("held_data", 64'(master_writedata), 64'(held_data));
            end
            if (master_write) begin
                if (wcount == 3) hold3++;
                if (wr) begin
                    stalls++;
                end else if (wcount >= N) begin
                    check("extra_write", 64'(wcount), 64'(N - 1));
                end else begin
                    check("wr_addr", 64'(master_address), 64'(BASE + 32'(wcount * 2)));
                    check("wr_data", 64'(master_writedata), 64'(mem[wcount]));
                    wcount++;
                end
                held_addr = master_address;
                held_data = master_writedata;
            end
            prev_stalled = master_write && wr;
            if (dump_done) begin
                done_cnt++;
                check("done_words", 64'(wcount), 64'(N));
                check("done_latency", 64'(cyc - start_cyc), 64'(N * CYC_PER_WORD + stalls));
            end
        end
    end

    task automatic fill_mem(input bit ramp);
        for (int i = 0; i < N; i++) mem[i] = ramp ? 16'(16'h1000 + i) : 16'($urandom);
    endtask

    task automatic pulse_fft_done();
        @(posedge clk); #2;
        fft_done = 1'b1;
        @(posedge clk); #2;
        fft_done = 1'b0;
    endtask

    // Wait for the frame to finish, then let the monitor see the IDLE cycle.
    task automatic wait_frame(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        check("frame_timeout", 64'(done_cnt != 0), 64'd1);
        repeat (4) @(posedge clk);
        #2;
        check("done_count", 64'(done_cnt), 64'd1);
        check("idle_after", 64'(dump_busy), 64'd0);
    endtask

    task automatic run_frame(input bit ramp, input int mode);
        fill_mem(ramp);
        stall_mode = mode;
        new_frame();
        pulse_fft_done();
        wait_frame(4 * N * CYC_PER_WORD + 100);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_raddr"}, 64'(rAddress), 64'd0);
        check({tag, "_addr"}, 64'(master_address), 64'd0);
        check({tag, "_write"}, 64'(master_write), 64'd0);
        check({tag, "_wdata"}, 64'(master_writedata), 64'd0);
        check({tag, "_be"}, 64'(master_byteenable), 64'd0);
        check({tag, "_busy"}, 64'(dump_busy), 64'd0);
        check({tag, "_done"}, 64'(dump_done), 64'd0);
    endtask

    initial begin
        int n;
        n_rst = 1'b0;
        fft_done = 1'b0;
`ifdef AVALON_RESULT_IRQ_EN
        irq_clear = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
`ifdef AVALON_RESULT_IRQ_EN
        check("reset_irq", 64'(dump_irq), 64'd0);
`endif
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("idle_nodone", 64'(dump_busy), 64'd0);

        // Basic ramp frame, no stalls.
        run_frame(1'b1, 0);
        check("basic_words", 64'(wcount), 64'(N));

        // Five-cycle stall on word 3: six cycles at the same address.
        run_frame(1'b1, 1);
        check("stall3_hold", 64'(hold3), 64'd6);
        check("stall3_count", 64'(stall3), 64'd5);

        // Retrigger at word 100 is ignored.
        fill_mem(1'b0);
        stall_mode = 0;
        new_frame();
        pulse_fft_done();
        n = 0;
        while (wcount < 100 && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        check("reach_w100", 64'(wcount >= 100), 64'd1);
        fft_done = 1'b1;
        @(posedge clk); #2;
        fft_done = 1'b0;
        wait_frame(2 * N * CYC_PER_WORD);
        check("retrig_words", 64'(wcount), 64'(N));

        // Random stalls with random data.
        run_frame(1'b0, 2);

        // Mid-frame reset during the write of word 50.
        fill_mem(1'b0);
        stall_mode = 0;
        new_frame();
        pulse_fft_done();
        n = 0;
        while (!(wcount >= 50 && master_write) && n < 1000) begin
            @(posedge clk); #2;
            n++;
        end
        check("reach_w50", 64'(master_write), 64'd1);
        n_rst = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (3) @(posedge clk);
        #2;
        check("midrst_nodone", 64'(done_cnt), 64'd0);
        n_rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check("midrst_idle", 64'(dump_busy), 64'd0);
        run_frame(1'b0, 0);
        check("restart_words", 64'(wcount), 64'(N));

`ifdef AVALON_RESULT_IRQ_EN
        check("irq_sticky", 64'(dump_irq), 64'd1);
        irq_clear = 1'b1;
        @(posedge clk); #2;
        irq_clear = 1'b0;
        check("irq_cleared", 64'(dump_irq), 64'd0);
        // Clear coincident with the next dump_done: set wins.
        fill_mem(1'b0);
        new_frame();
        pulse_fft_done();
        n = 0;
        while (!dump_done && n < 2 * N * CYC_PER_WORD) begin
            @(posedge clk); #2;
            n++;
        end
        check("irq_seen_done", 64'(dump_done), 64'd1);
        irq_clear = 1'b1;
        @(posedge clk); #2;
        irq_clear = 1'b0;
        check("irq_set_wins", 64'(dump_irq), 64'd1);
        repeat (3) @(posedge clk);
        #2;
        check("irq_still_set", 64'(dump_irq), 64'd1);
        irq_clear = 1'b1;
        @(posedge clk); #2;
        irq_clear = 1'b0;
        check("irq_clear_alone", 64'(dump_irq), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
